dht11_reader: RTL and testbench

Single-wire DHT11 sensor driver that produces the 40-bit measurement frame consumed by the command/control stage. On a `start` request it issues the host start pulse, times the sensor response and 40 data bits, verifies the checksum, and presents `data`/`done`/`error` as held levels. `done`/`error` stay valid until the next accepted `start`, so the control stage can sample them on any cycle.

---
 rtl/dht_pkg.sv | 42 ++++
 rtl/dht11_reader_us_tick.sv | 28 ++
 rtl/dht11_reader.sv | 185 ++++++++++++++++++
 tb/tb_dht11_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT11 single-wire reader and the
// control stage that consumes its 40-bit frame.
package dht_pkg;

    // Reader FSM states; exported on the debug port of dht11_reader.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_LOW = 4'd1,
        ST_RELEASE   = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_CHECK     = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    // Frame layout, MSB first: {RH int, RH dec, T int, T dec, checksum}.
    localparam int FRAME_BITS = 40;
    localparam int RH_INT_MSB = 39;
    localparam int RH_INT_LSB = 32;
    localparam int T_INT_MSB  = 23;
    localparam int T_INT_LSB  = 16;
    localparam int CSUM_MSB   = 7;
    localparam int CSUM_LSB   = 0;

    // Width of the microsecond phase counter.
    localparam int US_CNT_W = 15;

    // Default timing, in microseconds.
    localparam int DEF_START_LOW_US   = 18000;
    localparam int DEF_TIMEOUT_US     = 100;
    localparam int DEF_BIT1_THRESH_US = 40;

    // Modulo-256 sum of the four payload bytes.
    function automatic logic [7:0] frame_csum(input logic [FRAME_BITS-1:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return s;
    endfunction

endpackage

// File: rtl/dht11_reader_us_tick.sv
// Free-running divider that emits a one-cycle strobe every DIV clocks.
// With DIV = 1 the strobe is permanently high.
module us_tick #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    // Divider counter: wraps to zero on the strobe cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: issues the host start pulse, times the sensor
// response and 40 data bits, verifies the checksum and holds the result.
//
// Handshake: start is a request level sampled every clock; it is accepted
// only while busy = 0 (IDLE or DONE). done/error/data are held levels that
// stay valid from the rising edge of done until the next accepted start.
module dht11_reader
    import dht_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int START_LOW_US   = DEF_START_LOW_US,
    parameter int TIMEOUT_US     = DEF_TIMEOUT_US,
    parameter int BIT1_THRESH_US = DEF_BIT1_THRESH_US
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dht_in,
    output logic                  dht_oe,
    output logic                  busy,
    output logic [FRAME_BITS-1:0] data,
    output logic                  done,
    output logic                  error,
    output state_t                dbg_state
);

    localparam int TICK_DIV = CLK_FREQ_HZ / 1_000_000;

    state_t                state;
    logic [US_CNT_W-1:0]   us_cnt;
    logic [US_CNT_W:0]     us_now;
    logic [FRAME_BITS-1:0] shreg;
    logic [5:0]            bit_cnt;
    logic                  tick;
    logic                  sync_1, sync_2, sync_prev;
    logic                  fall, rise;
    logic                  wait_fall, wait_rise, sensor_phase, edge_hit;
    logic                  timed_out, bit_val;

    us_tick #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchronizer plus one history flop for edge detection;
    // the idle line is pulled up, so everything resets high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_1    <= dht_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign fall = sync_prev & ~sync_2;
    assign rise = ~sync_prev & sync_2;

    // Elapsed microseconds in the current phase, counting a tick that
    // lands on this very cycle so a phase of N us reads exactly N.
    assign us_now    = {1'b0, us_cnt} + {{US_CNT_W{1'b0}}, tick};
    assign timed_out = (us_now >= 16'(TIMEOUT_US));
    assign bit_val   = (us_now > 16'(BIT1_THRESH_US));

    // Which line edge ends the current sensor-driven phase.
    always_comb begin
        wait_fall = 1'b0;
        wait_rise = 1'b0;
        case (state)
            ST_RELEASE, ST_RESP_HIGH, ST_BIT_HIGH: wait_fall = 1'b1;
            ST_RESP_LOW, ST_BIT_LOW:               wait_rise = 1'b1;
            default: ;
        endcase
        sensor_phase = wait_fall | wait_rise;
        edge_hit     = (wait_fall & fall) | (wait_rise & rise);
    end

    // Main FSM with registered outputs; any state change clears the us counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            us_cnt  <= '0;
            dht_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            data    <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (tick && us_cnt != '1) begin
                us_cnt <= us_cnt + 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_START_LOW;
                        us_cnt  <= '0;
                        dht_oe  <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_START_LOW: begin
                    if (us_now >= 16'(START_LOW_US)) begin
                        state  <= ST_RELEASE;
                        us_cnt <= '0;
                        dht_oe <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (edge_hit) begin
                        state  <= ST_RESP_LOW;
                        us_cnt <= '0;
                    end
                end
                ST_RESP_LOW: begin
                    if (edge_hit) begin
                        state  <= ST_RESP_HIGH;
                        us_cnt <= '0;
                    end
                end
                ST_RESP_HIGH: begin
                    if (edge_hit) begin
                        state  <= ST_BIT_LOW;
                        us_cnt <= '0;
                    end
                end
                ST_BIT_LOW: begin
                    if (edge_hit) begin
                        state  <= ST_BIT_HIGH;
                        us_cnt <= '0;
                    end
                end
                ST_BIT_HIGH: begin
                    if (edge_hit) begin
                        shreg   <= {shreg[FRAME_BITS-2:0], bit_val};
                        bit_cnt <= bit_cnt + 1'b1;
                        us_cnt  <= '0;
                        if (bit_cnt == 6'(FRAME_BITS - 1)) begin
                            state <= ST_CHECK;
                        end else begin
                            state <= ST_BIT_LOW;
                        end
                    end
                end
                ST_CHECK: begin
                    state  <= ST_DONE;
                    us_cnt <= '0;
                    data   <= shreg;
                    error  <= (frame_csum(shreg) != shreg[CSUM_MSB:CSUM_LSB]);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    us_cnt <= '0;
                end
            endcase

            // A sensor phase that overruns ends the transaction with no data.
            if (sensor_phase && !edge_hit && timed_out) begin
                state  <= ST_DONE;
                us_cnt <= '0;
                data   <= '0;
                error  <= 1'b1;
                done   <= 1'b1;
                busy   <= 1'b0;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader with a behavioural DHT11 sensor model at 1 MHz.
`timescale 1ns/1ps
module tb_dht11_reader;
    import dht_pkg::*;

    localparam logic [39:0] FRAME_OK  = 40'h37001A0051;
    localparam logic [39:0] FRAME_BAD = 40'h37001A0052;

    logic        clk;
    logic        rst;
    logic        start;
    logic        dht_in;
    logic        dht_oe;
    logic        busy;
    logic [39:0] data;
    logic        done;
    logic        error;
    state_t      dbg_state;

    logic        sens_low;
    logic [40:0] exp_q[$];
    int          checks;
    int          errors;
    int          oe_rises;

    // Open-drain line: host or sensor pulls low, otherwise the pull-up wins.
    assign dht_in = (dht_oe || sens_low) ? 1'b0 : 1'b1;

    dht11_reader #(
        .CLK_FREQ_HZ   (1_000_000),
        .START_LOW_US  (50),
        .TIMEOUT_US    (100),
        .BIT1_THRESH_US(40)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dht_in   (dht_in),
        .dht_oe   (dht_oe),
        .busy     (busy),
        .data     (data),
        .done     (done),
        .error    (error),
        .dbg_state(dbg_state)
    );

    // Clock and reset: 1 MHz clock, one cycle = 1 us.
    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    // Wait n clock edges and settle just after the last one.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        hold(1);
        start = 1'b0;
    endtask

    // Sensor model: measures the host low pulse, then answers with nbits
    // bits of f (nbits < 0: never answers; nbits < 40: line left high).
    task automatic run_sensor(input logic [39:0] f, input int nbits,
                              input int h0, input int h1, output int oe_len);
        int n;
        n = 0;
        oe_len = 0;
        while (!dht_oe && n < 20) begin
            hold(1);
            n++;
        end
        while (dht_oe && oe_len < 1000) begin
            oe_len++;
            hold(1);
        end
        if (nbits < 0) return;
        hold(30);
        sens_low = 1'b1; hold(80);
        sens_low = 1'b0; hold(80);
        for (int i = 0; i < nbits; i++) begin
            sens_low = 1'b1; hold(50);
            sens_low = 1'b0; hold(f[39-i] ? h1 : h0);
        end
        if (nbits == 40) begin
            sens_low = 1'b1; hold(50);
            sens_low = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 8000) begin
            hold(1);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: done never rose (got 0 expected 1)", name);
        end
        hold(1);
    endtask

    // Monitor: on each rising edge of done, pop and compare {error, data};
    // also counts host start pulses.
    initial begin
        logic        done_prev;
        logic        oe_prev;
        logic [40:0] exp;
        done_prev = 1'b0;
        oe_prev   = 1'b0;
        oe_rises  = 0;
        forever begin
            @(negedge clk);
            if (dht_oe && !oe_prev) oe_rises++;
            oe_prev = dht_oe;
            if (rst) begin
                done_prev = 1'b0;
            end else begin
                if (done && !done_prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected: got %0h with empty queue", {error, data});
                    end else begin
                        exp = exp_q.pop_front();
                        if ({error, data} !== exp) begin
                            errors++;
                            $display("FAIL result: got err=%0b data=%h expected err=%0b data=%h",
                                     error, data, exp[40], exp[39:0]);
                        end
                    end
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_at_done: got %0b expected 0", busy);
                    end
                end
                done_prev = done;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int len;
        int n;
        int oe_before;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        sens_low = 1'b0;
        hold(3);
        check("rst_oe",    64'(dht_oe), 64'd0);
        check("rst_busy",  64'(busy),   64'd0);
        check("rst_done",  64'(done),   64'd0);
        check("rst_error", 64'(error),  64'd0);
        check("rst_data",  64'(data),   64'd0);
        rst = 1'b0;
        hold(3);

        // Valid frame, nominal bit timing.
        exp_q.push_back({1'b0, FRAME_OK});
        do_start();
        check("start_oe",   64'(dht_oe), 64'd1);
        check("start_busy", 64'(busy),   64'd1);
        run_sensor(FRAME_OK, 40, 27, 70, len);
        check("oe_len", 64'(len), 64'd50);
        wait_done("valid");

        // No response after release: timeout 100 us after dht_oe falls.
        exp_q.push_back({1'b1, 40'h0});
        do_start();
        run_sensor(FRAME_OK, -1, 27, 70, len);
        n = 0;
        while (!done && n < 300) begin
            hold(1);
            n++;
        end
        check("timeout_window", 64'(n >= 99 && n <= 101), 64'd1);
        hold(2);

        // Bad checksum: raw bits returned with error.
        exp_q.push_back({1'b1, FRAME_BAD});
        do_start();
        run_sensor(FRAME_BAD, 40, 27, 70, len);
        wait_done("bad_csum");

        // Sensor stops after 20 bits, then a clean retry.
        exp_q.push_back({1'b1, 40'h0});
        do_start();
        run_sensor(FRAME_OK, 20, 27, 70, len);
        wait_done("stuck");
        exp_q.push_back({1'b0, FRAME_OK});
        do_start();
        run_sensor(FRAME_OK, 40, 27, 70, len);
        wait_done("retry");

        // Reset in the middle of bit 15.
        do_start();
        run_sensor(FRAME_OK, 15, 27, 70, len);
        sens_low = 1'b1;
        hold(20);
        rst = 1'b1;
        #10;
        check("midrst_oe",   64'(dht_oe), 64'd0);
        check("midrst_busy", 64'(busy),   64'd0);
        check("midrst_done", 64'(done),   64'd0);
        check("midrst_data", 64'(data),   64'd0);
        hold(2);
        rst      = 1'b0;
        sens_low = 1'b0;
        hold(3);

        // Start pulses during busy are ignored.
        exp_q.push_back({1'b0, FRAME_OK});
        oe_before = oe_rises;
        do_start();
        hold(5);
        do_start();
        fork
            run_sensor(FRAME_OK, 40, 27, 70, len);
            begin
                hold(400);
                do_start();
            end
        join
        wait_done("busy_ignore");
        check("start_low_count", 64'(oe_rises - oe_before), 64'd1);

        // Threshold boundary: 40 us high is 0, 41 us high is 1.
        exp_q.push_back({1'b0, FRAME_OK});
        do_start();
        run_sensor(FRAME_OK, 40, 40, 41, len);
        wait_done("threshold");

        hold(5);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
